// File: rtl/sample_ser_tx.sv
// sample_ser_tx: transmit end of the signed sample link.
// Accepts one parallel sample per valid/ready handshake and sends it bit-serially,
// MSB (index 0) first, with a frame-sync strobe on the first bit.
// Optional build macro SAMPLE_SER_TX_PARITY_EN appends one even-parity bit per frame.
module sample_ser_tx #(
  parameter int WIDTH    = 12,  // sample width, 2..32
  parameter int IDLE_GAP = 1    // forced idle cycles after each frame, 0..15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [0:WIDTH-1] s_data,
  output logic                    tx_bit,
  output logic                    tx_sync,
  output logic                    tx_active,
  output logic                    busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
`ifdef SAMPLE_SER_TX_PARITY_EN
    ST_GAP   = 2'd2,
    ST_PARITY = 2'd3
`else
    ST_GAP   = 2'd2
`endif
  } state_e;

  // Counter holds up to WIDTH (32) presented bits or IDLE_GAP-1 gap cycles.
  localparam logic [5:0] WIDTH_C  = 6'(WIDTH);
  localparam logic [5:0] GAP_LAST = 6'(IDLE_GAP - 1);
  localparam bit         HAS_GAP  = (IDLE_GAP > 0);

  state_e             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   sh_q, sh_d;        // remaining bits; [WIDTH-1] is next to send
  logic               tx_bit_q, tx_bit_d;
  logic               tx_sync_q, tx_sync_d;
  logic               tx_active_q, tx_active_d;
  logic               accept;
`ifdef SAMPLE_SER_TX_PARITY_EN
  logic               par_q, par_d;      // even parity of the frame being sent
`endif

  // The producer may only hand over a sample while idle and out of reset.
  assign s_ready   = (state_q == ST_IDLE) && !rst;
  assign accept    = s_valid && s_ready;
  assign busy      = (state_q != ST_IDLE);
  assign tx_bit    = tx_bit_q;
  assign tx_sync   = tx_sync_q;
  assign tx_active = tx_active_q;

  // State, datapath and registered serial outputs.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      tx_bit_q    <= 1'b0;
      tx_sync_q   <= 1'b0;
      tx_active_q <= 1'b0;
`ifdef SAMPLE_SER_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      tx_bit_q    <= tx_bit_d;
      tx_sync_q   <= tx_sync_d;
      tx_active_q <= tx_active_d;
`ifdef SAMPLE_SER_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  // Next state, bit counter and shift register.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
`ifdef SAMPLE_SER_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT;
          cnt_d   = 6'd1;                      // bit 0 goes out on this edge
          sh_d    = {s_data[1:WIDTH-1], 1'b0};
`ifdef SAMPLE_SER_TX_PARITY_EN
          par_d   = ^s_data;
`endif
        end
      end
      ST_SHIFT: begin
        if (cnt_q == WIDTH_C) begin
          cnt_d = '0;
`ifdef SAMPLE_SER_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = HAS_GAP ? ST_GAP : ST_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + 6'd1;
          sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        end
      end
`ifdef SAMPLE_SER_TX_PARITY_EN
      ST_PARITY: begin
        cnt_d   = '0;
        state_d = HAS_GAP ? ST_GAP : ST_IDLE;
      end
`endif
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Next values of the registered serial outputs; idle/gap cycles drive zeros.
  always_comb begin
    tx_bit_d    = 1'b0;
    tx_sync_d   = 1'b0;
    tx_active_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tx_bit_d    = s_data[0];
          tx_sync_d   = 1'b1;
          tx_active_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != WIDTH_C) begin
          tx_bit_d    = sh_q[WIDTH-1];
          tx_active_d = 1'b1;
        end else begin
`ifdef SAMPLE_SER_TX_PARITY_EN
          tx_bit_d    = par_q;
          tx_active_d = 1'b1;
`endif
        end
      end
      default: begin
        tx_bit_d    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sample_ser_tx.sv
// Directed bench for sample_ser_tx: two instances (IDLE_GAP=1 and IDLE_GAP=0).
module tb_sample_ser_tx;

`ifdef SAMPLE_SER_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FL = 12 + P;  // tx_active cycles per frame

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid0 = 1'b0, s_valid1 = 1'b0;
  logic [11:0] s_data0 = '0, s_data1 = '0;
  logic        s_ready0, tx_bit0, tx_sync0, tx_active0, busy0;
  logic        s_ready1, tx_bit1, tx_sync1, tx_active1, busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sample_ser_tx #(.WIDTH(12), .IDLE_GAP(1)) dut0 (
    .clk(clk), .rst(rst), .s_valid(s_valid0), .s_ready(s_ready0), .s_data(s_data0),
    .tx_bit(tx_bit0), .tx_sync(tx_sync0), .tx_active(tx_active0), .busy(busy0)
  );

  sample_ser_tx #(.WIDTH(12), .IDLE_GAP(0)) dut1 (
    .clk(clk), .rst(rst), .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
    .tx_bit(tx_bit1), .tx_sync(tx_sync1), .tx_active(tx_active1), .busy(busy1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected 16-cycle tx_bit trace starting at the first bit of a frame.
  function automatic logic [15:0] exp_bits(input logic [11:0] d);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 12; i++) v[i] = d[11-i];
    if (P == 1) v[12] = ^d;
    return v;
  endfunction

  function automatic logic [15:0] low_mask(input int n);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i] = (i < n);
    return v;
  endfunction

  // Send one sample to dut0 (assumed idle) and record 16 cycles of outputs.
  task automatic capture(input logic [11:0] d, input bit scramble,
                         output logic [15:0] b, output logic [15:0] s,
                         output logic [15:0] a, output logic [15:0] r);
    s_valid0 = 1'b1;
    s_data0  = d;
    step();
    s_valid0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b[i] = tx_bit0;
      s[i] = tx_sync0;
      a[i] = tx_active0;
      r[i] = s_ready0;
      if (scramble) s_data0 = 12'($urandom);
      step();
    end
    s_data0 = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({tx_bit0, tx_sync0, tx_active0, busy0, s_ready0} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000", {tx_bit0, tx_sync0, tx_active0, busy0, s_ready0});
    end
    step();
    step();
    rst = 1'b0;
    step();
    checks++;
    if (s_ready0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: ready=%b busy=%b expected ready=1 busy=0", s_ready0, busy0);
    end
  endtask

  task automatic test_frame(input string name, input logic [11:0] d, input bit scramble);
    logic [15:0] b, s, a, r;
    capture(d, scramble, b, s, a, r);
    checks++;
    if (b !== exp_bits(d)) begin
      errors++;
      $display("FAIL %s_bits: got %b expected %b", name, b, exp_bits(d));
    end
    checks++;
    if (s !== 16'h0001) begin
      errors++;
      $display("FAIL %s_sync: got %b expected %b", name, s, 16'h0001);
    end
    checks++;
    if (a !== low_mask(FL)) begin
      errors++;
      $display("FAIL %s_active: got %b expected %b", name, a, low_mask(FL));
    end
    checks++;
    if (r !== ~low_mask(FL + 1)) begin
      errors++;
      $display("FAIL %s_ready: got %b expected %b", name, r, ~low_mask(FL + 1));
    end
  endtask

  task automatic test_parity();
`ifdef SAMPLE_SER_TX_PARITY_EN
    logic [15:0] b, s, a, r;
    capture(12'h5A3, 1'b0, b, s, a, r);
    checks++;
    if (b !== 16'b0000_0_1100_0101_1010) begin
      errors++;
      $display("FAIL parity_5a3_bits: got %b expected %b", b, 16'b0000_0_1100_0101_1010);
    end
    checks++;
    if (a !== 16'h1FFF) begin
      errors++;
      $display("FAIL parity_5a3_active: got %h expected 1fff", a);
    end
`endif
  endtask

  // Held s_valid on an instance; measures sync-to-sync period and bits of frame 1.
  task automatic test_back_to_back(input bit use_gap0, input logic [11:0] d1,
                                   input logic [11:0] d2, input int exp_period);
    logic [11:0] bits1;
    int          period;
    logic        act_after, rdy_after;
    bits1 = '0; period = -1; act_after = 1'bx; rdy_after = 1'bx;
    if (use_gap0) begin s_valid1 = 1'b1; s_data1 = d1; end
    else          begin s_valid0 = 1'b1; s_data0 = d1; end
    step();
    checks++;
    if ((use_gap0 ? tx_sync1 : tx_sync0) !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_sync gap0=%0d: got %b expected 1", use_gap0, use_gap0 ? tx_sync1 : tx_sync0);
    end
    bits1[11] = use_gap0 ? tx_bit1 : tx_bit0;
    if (use_gap0) s_data1 = d2; else s_data0 = d2;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k < 12) bits1[11-k] = use_gap0 ? tx_bit1 : tx_bit0;
      if (k == FL) begin
        act_after = use_gap0 ? tx_active1 : tx_active0;
        rdy_after = use_gap0 ? s_ready1 : s_ready0;
      end
      if ((use_gap0 ? tx_sync1 : tx_sync0) === 1'b1) begin
        period = k;
        break;
      end
    end
    s_valid0 = 1'b0; s_valid1 = 1'b0;
    checks++;
    if (period != exp_period) begin
      errors++;
      $display("FAIL b2b_period gap0=%0d: got %0d expected %0d", use_gap0, period, exp_period);
    end
    checks++;
    if (bits1 !== d1) begin
      errors++;
      $display("FAIL b2b_frame1_bits gap0=%0d: got %h expected %h", use_gap0, bits1, d1);
    end
    checks++;
    if ((use_gap0 ? tx_bit1 : tx_bit0) !== d2[11]) begin
      errors++;
      $display("FAIL b2b_frame2_msb gap0=%0d: got %b expected %b", use_gap0, use_gap0 ? tx_bit1 : tx_bit0, d2[11]);
    end
    if (use_gap0) begin
      checks++;
      if (act_after !== 1'b0 || rdy_after !== 1'b1) begin
        errors++;
        $display("FAIL gap0_idle_cycle: active=%b ready=%b expected active=0 ready=1", act_after, rdy_after);
      end
    end
    // let both instances drain back to idle
    for (int k = 0; k < 40 && (busy0 || busy1); k++) step();
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: busy0=%b busy1=%b expected 0 0", busy0, busy1);
    end
  endtask

  task automatic test_reset_mid_frame();
    s_valid0 = 1'b1;
    s_data0  = 12'h7FF;
    step();
    s_valid0 = 1'b0;
    repeat (5) step();  // now presenting bit 5
    checks++;
    if (tx_active0 !== 1'b1 || tx_bit0 !== 1'b1) begin
      errors++;
      $display("FAIL midframe_pre: active=%b bit=%b expected 1 1", tx_active0, tx_bit0);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({tx_bit0, tx_sync0, tx_active0, busy0, s_ready0} !== 5'b0) begin
      errors++;
      $display("FAIL midframe_async_reset: got %b expected 00000", {tx_bit0, tx_sync0, tx_active0, busy0, s_ready0});
    end
    step();
    step();
    rst = 1'b0;
    test_frame("after_reset_000", 12'h000, 1'b0);
  endtask

  initial begin
    test_reset();
    test_frame("msb_800", 12'h800, 1'b0);
    test_frame("pattern_5a3", 12'h5A3, 1'b0);
    test_parity();
    test_back_to_back(1'b0, 12'h001, 12'hFFF, 14 + P);
    test_back_to_back(1'b1, 12'h5A3, 12'h0F0, 13 + P);
    test_reset_mid_frame();
    test_frame("data_change_123", 12'h123, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
